// File: rtl/seg7_scan_decoder.sv
// Recovers six hex digits from a time-multiplexed, active-low seven-segment bus.
// Optional SEG7_BLANK_EN: treat 7'h7F as a legal blank rather than an error.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [2:0]  dig_sel,
  input  logic        seg_strobe,
  input  logic        err_clr,
  output logic [23:0] value,
  output logic [5:0]  digit_valid,
  output logic [5:0]  err,
  output logic        update
);

  localparam logic [3:0] LP_STABLE = 4'(STABLE_COUNT);

  // Returns {decodable, nibble}.
  function automatic logic [4:0] f_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h18:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]  r_cand [6];
  logic [3:0]  r_cnt  [6];
  logic [23:0] r_value;
  logic [5:0]  r_valid;
  logic [5:0]  r_err;
  logic        r_update;

  logic [4:0]  w_dec;
  logic        w_blank;
  logic [5:0]  w_sel;
  logic [5:0]  w_match;
  logic [5:0]  w_commit;
  logic [3:0]  w_cnt_nx [6];
  logic [5:0]  w_err_nx;

  always_comb begin
    w_dec = f_decode(seg);
`ifdef SEG7_BLANK_EN
    w_blank = (seg == 7'h7F);
`else
    w_blank = 1'b0;
`endif
    w_sel    = '0;
    w_match  = '0;
    w_commit = '0;
    for (int d = 0; d < 6; d++) begin
      w_sel[d]   = seg_strobe && (dig_sel == 3'(d));
      w_match[d] = (seg == r_cand[d]);
      if (!w_match[d])                w_cnt_nx[d] = 4'd1;
      else if (r_cnt[d] >= LP_STABLE) w_cnt_nx[d] = r_cnt[d];
      else                            w_cnt_nx[d] = r_cnt[d] + 4'd1;
      // A mismatch at saturation can only re-commit when STABLE_COUNT is 1.
      w_commit[d] = w_sel[d] && (w_cnt_nx[d] == LP_STABLE) &&
                    (!w_match[d] || (r_cnt[d] != LP_STABLE));
    end
    w_err_nx = (err_clr ? 6'b0 : r_err) | (w_commit & {6{~w_dec[4] & ~w_blank}});
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int d = 0; d < 6; d++) begin
        r_cand[d] <= 7'h7F;
        r_cnt[d]  <= 4'd0;
      end
      r_value  <= '0;
      r_valid  <= '0;
      r_err    <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= |w_commit;
      r_err    <= w_err_nx;
      for (int d = 0; d < 6; d++) begin
        if (w_sel[d]) begin
          r_cand[d] <= seg;
          r_cnt[d]  <= w_cnt_nx[d];
        end
        if (w_commit[d]) begin
          r_valid[d] <= w_dec[4];
          if (w_dec[4]) r_value[4*d +: 4] <= w_dec[3:0];
        end
      end
    end
  end

  assign value       = r_value;
  assign digit_valid = r_valid;
  assign err         = r_err;
  assign update      = r_update;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: run-length model compared every cycle,
// plus literal checkpoints from the hand-worked scenarios.
module tb_seg7_scan_decoder;

  localparam int STABLE = 3;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [2:0]  dig_sel = 3'd0;
  logic        seg_strobe = 1'b0;
  logic        err_clr = 1'b0;
  logic [23:0] value;
  logic [5:0]  digit_valid;
  logic [5:0]  err;
  logic        update;

  seg7_scan_decoder #(.STABLE_COUNT(STABLE)) u_dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .seg_strobe  (seg_strobe),
    .err_clr     (err_clr),
    .value       (value),
    .digit_valid (digit_valid),
    .err         (err),
    .update      (update)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each digit remembers its last pattern and how many times in a
  // row it has been seen; the decode commits exactly when that run length hits STABLE.
  logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_last [6];
  int          m_run  [6];
  logic [23:0] m_value;
  logic [5:0]  m_valid;
  logic [5:0]  m_err;
  logic        m_update;
  bit          started = 0;

  task automatic model_step(input logic st, input logic [2:0] d, input logic [6:0] p,
                            input logic clr, input logic rst);
    int nib;
    bit blank;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_last[i] = 'h7F;
        m_run[i]  = 0;
      end
      m_value = '0; m_valid = '0; m_err = '0; m_update = 0;
      return;
    end
    m_update = 0;
    if (clr) m_err = '0;
    if (st && d < 6) begin
      if (int'(p) == m_last[d]) m_run[d]++;
      else begin
        m_last[d] = int'(p);
        m_run[d]  = 1;
      end
      if (m_run[d] == STABLE) begin
        nib = -1;
        for (int k = 0; k < 16; k++) if (tbl[k] == p) nib = k;
`ifdef SEG7_BLANK_EN
        blank = (p == 7'h7F);
`else
        blank = 0;
`endif
        m_update = 1;
        if (nib >= 0) begin
          m_value[4*d +: 4] = 4'(nib);
          m_valid[d] = 1'b1;
        end else begin
          m_valid[d] = 1'b0;
          if (!blank) m_err[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] d, input logic [6:0] p,
                       input logic clr, input logic rst);
    @(negedge CLOCK_50);
    seg_strobe = st; dig_sel = d; seg = p; err_clr = clr; reset = rst;
    @(posedge CLOCK_50);
    model_step(st, d, p, clr, rst);
    started = 1;
    #1;
  endtask

  task automatic strobe(input logic [2:0] d, input logic [6:0] p);
    drive(1'b1, d, p, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 7'h00, 1'b0, 1'b0);
  endtask

  always @(negedge CLOCK_50) begin
    if (started) begin
      chk("value",       32'(value),       32'(m_value));
      chk("digit_valid", 32'(digit_valid), 32'(m_valid));
      chk("err",         32'(err),         32'(m_err));
      chk("update",      32'(update),      32'(m_update));
    end
  end

  int upd_cnt;

  initial begin
    drive(1'b0, 3'd0, 7'h7F, 1'b0, 1'b1);
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_valid", 32'(digit_valid), 32'h0);
    chk("reset_update", 32'(update), 32'h0);

    // Digit 0, pattern for '2', with idle gaps that must not break the run.
    strobe(3'd0, 7'h24);
    idle();
    strobe(3'd0, 7'h24);
    chk("t1_no_early", 32'(update), 32'h0);
    idle();
    idle();
    strobe(3'd0, 7'h24);
    chk("t1_nib", 32'(value[3:0]), 32'h2);
    chk("t1_valid", 32'(digit_valid), 32'h01);
    chk("t1_upd", 32'(update), 32'h1);
    idle();
    chk("t1_upd_drop", 32'(update), 32'h0);
    strobe(3'd0, 7'h24);
    chk("t1_no_recommit", 32'(update), 32'h0);

    // All sixteen table entries on digit 5.
    upd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < 3; r++) begin
        strobe(3'd5, tbl[i]);
        upd_cnt += int'(update);
      end
      chk("t2_nib", 32'(value[23:20]), 32'(i));
    end
    chk("t2_upd_count", 32'(upd_cnt), 32'd16);
    chk("t2_err", 32'(err), 32'h0);

    // A pattern change restarts the run.
    strobe(3'd2, 7'h19);
    strobe(3'd2, 7'h19);
    strobe(3'd2, 7'h12);
    strobe(3'd2, 7'h12);
    chk("t3_no_commit", 32'(update), 32'h0);
    strobe(3'd2, 7'h12);
    chk("t3_nib", 32'(value[11:8]), 32'h5);
    chk("t3_upd", 32'(update), 32'h1);

    // Undecodable pattern, then set-vs-clear collision, then a lone clear.
    for (int r = 0; r < 3; r++) strobe(3'd3, 7'h55);
    chk("t4_err", 32'(err), 32'h08);
    chk("t4_valid3", 32'(digit_valid[3]), 32'h0);
    strobe(3'd3, 7'h56);
    strobe(3'd3, 7'h56);
    drive(1'b1, 3'd3, 7'h56, 1'b1, 1'b0);
    chk("t4_set_wins", 32'(err), 32'h08);
    drive(1'b0, 3'd0, 7'h00, 1'b1, 1'b0);
    chk("t4_cleared", 32'(err), 32'h0);

    // Reset mid-filter, asserted together with a strobe and err_clr.
    strobe(3'd1, 7'h30);
    strobe(3'd1, 7'h30);
    drive(1'b1, 3'd1, 7'h30, 1'b1, 1'b1);
    strobe(3'd1, 7'h30);
    chk("t5_value0", 32'(value), 32'h0);
    chk("t5_valid0", 32'(digit_valid), 32'h0);
    chk("t5_upd0", 32'(update), 32'h0);
    strobe(3'd1, 7'h30);
    strobe(3'd1, 7'h30);
    chk("t5_nib", 32'(value[7:4]), 32'h3);
    chk("t5_upd", 32'(update), 32'h1);

    // Digit 4: commit '4', then the all-off pattern.
    for (int r = 0; r < 3; r++) strobe(3'd4, 7'h19);
    chk("t6_pre_valid", 32'(digit_valid), 32'h12);
    for (int r = 0; r < 3; r++) strobe(3'd4, 7'h7F);
    chk("t6_upd", 32'(update), 32'h1);
    chk("t6_valid", 32'(digit_valid), 32'h02);
    chk("t6_nib_kept", 32'(value), 32'h040030);
`ifdef SEG7_BLANK_EN
    chk("t6_err", 32'(err), 32'h00);
`else
    chk("t6_err", 32'(err), 32'h10);
`endif

    // Out-of-range digit indices are ignored, including inside a pending run.
    strobe(3'd0, 7'h79);
    strobe(3'd6, 7'h40);
    strobe(3'd0, 7'h79);
    strobe(3'd7, 7'h40);
    chk("t7_no_commit", 32'(update), 32'h0);
    for (int r = 0; r < 3; r++) strobe(3'd6, 7'h40);
    chk("t7_value", 32'(value), 32'h040030);
    strobe(3'd0, 7'h79);
    chk("t7_nib0", 32'(value[3:0]), 32'h1);
    chk("t7_valid", 32'(digit_valid), 32'h03);
    idle();
    idle();

    @(negedge CLOCK_50);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the seven-segment encoder: samples a time-multiplexed, active-low segment bus (one digit index and one 7-bit pattern per strobe), filters each digit for stability, and decodes the committed patterns back into hex nibbles. Used in the ALU test fixtures and on-board loopback to recover the six displayed digits (HEX0..HEX5) as a 24-bit value. Decoded results are registered, with per-digit valid and sticky error flags.

## Interface
- STABLE_COUNT, 3, consecutive identical strobes per digit required before commit; legal range 1..15
- CLOCK_50  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- seg  input  7  active-low segment pattern, bit 0 = segment a … bit 6 = segment g
- dig_sel  input  3  digit index 0..5; values 6, 7 are ignored
- seg_strobe  input  1  seg/dig_sel are valid this cycle
- err_clr  input  1  clears all err bits
- value  output  24  decoded digits, nibble d = value[4d+3:4d]
- digit_valid  output  6  bit d set when nibble d holds a committed decode
- err  output  6  sticky: bit d set when digit d committed an undecodable pattern
- update  output  1  one-cycle pulse when any nibble or valid bit is committed

## Operation
- Decode table (seg[6:0] -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex). Any other pattern is undecodable.
- Per digit d: candidate pattern cand[d] (7 b) and count cnt[d] (4 b, saturating at STABLE_COUNT).
- On a strobe with dig_sel = d ≤ 5 and pattern p:
  - p == cand[d]: cnt[d] += 1, saturating at STABLE_COUNT.
  - p != cand[d]: cand[d] = p, cnt[d] = 1.
- Commit occurs only on the strobe where cnt[d] first reaches STABLE_COUNT. Further identical strobes do not re-commit.
  - Decodable p: nibble d = decode(p), digit_valid[d] = 1, update pulses.
  - Undecodable p: digit_valid[d] = 0, err[d] = 1, nibble d unchanged, update pulses.
- A strobe with dig_sel 6 or 7 changes no state.
- Non-strobe cycles change no state except for err_clr.
- err_clr clears all err bits. If err_clr and an error commit occur in the same cycle, the set wins for that digit.
- With STABLE_COUNT = 1, every changed pattern commits on its first strobe.

## Timing
- Inputs are sampled at edge E. cand/cnt update at edge E. value, digit_valid, err and update are registered at edge E and are visible from E until the next edge.
- Latency: the first strobe plus STABLE_COUNT−1 further matching strobes, then outputs at that last strobe's edge. Idle cycles between strobes are allowed and do not reset counts.
- Reset values: value = 0, digit_valid = 0, err = 0, update = 0, cand[d] = 7'h7F, cnt[d] = 0.
- Reset asserted mid-filter discards partial counts. The first strobe after reset starts at cnt = 1.
- Reset has priority over seg_strobe and err_clr in the same cycle.

## Configuration
- SEG7_BLANK_EN defined: pattern 7'h7F (all segments off) is a legal blank. Its commit clears digit_valid[d], does not set err[d], leaves the nibble unchanged, and pulses update.
- SEG7_BLANK_EN undefined: 7'h7F is undecodable and is treated like any other error pattern.

## Test plan
- Reset, then three strobes dig 0, seg 0x24 -> after the 3rd strobe's edge: value[3:0] = 2, digit_valid = 6'b000001, update high for exactly 1 cycle. A 4th identical strobe produces no update.
- All 16 table patterns on dig 5, three strobes each -> value[23:20] steps 0..F with 16 update pulses and err = 0.
- Dig 2 strobes 0x19, 0x19, 0x12, 0x12, 0x12 -> no commit until the 5th strobe, then value[11:8] = 5.
- Three strobes dig 3, seg 0x55 -> err = 6'b001000, digit_valid[3] = 0. Assert err_clr in the same cycle as a second error commit -> err[3] stays 1. err_clr alone on a later cycle -> err = 0.
- Two strobes dig 1, seg 0x30, then reset, then one strobe 0x30 -> no commit, all outputs 0. Two more strobes -> commit value[7:4] = 3.
- Three strobes dig 4, seg 0x7F -> with SEG7_BLANK_EN: digit_valid[4] = 0, err = 0. Without it: err[4] = 1. Dig_sel = 6 strobes change nothing.
